// File: rtl/sc_io_pkg.sv
// Shared constants for the single-cycle computer's input port: key count,
// ip1 field layout and the I/O read addresses decoded by data memory.
package sc_io_pkg;

  localparam int KEY_W     = 4;
  localparam int PEND_LSB  = 0;
  localparam int LEVEL_LSB = 4;
  localparam int CNT_LSB   = 8;
  localparam int CNT_W_EV  = 8;

  localparam logic [31:0] IP0_ADDR = 32'h0000_00F0;
  localparam logic [31:0] IP1_ADDR = 32'h0000_00F4;

  // Number of keys that register a press on the same clock edge.
  function automatic logic [CNT_W_EV-1:0] count_events(input logic [KEY_W-1:0] ev);
    logic [CNT_W_EV-1:0] n;
    n = '0;
    for (int i = 0; i < KEY_W; i++) begin
      n = n + CNT_W_EV'(ev[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/sc_io_debounce.sv
// One input bit: two-flop synchroniser, stability counter and accepted level.
// fall_o pulses on the edge where the accepted level goes 1 -> 0.
module sc_debounce #(
  parameter int   DB_CYCLES = 50000,
  parameter int   CNT_W     = 16,
  parameter logic RST_VAL   = 1'b0
) (
  input  logic clock,
  input  logic resetn,
  input  logic raw_i,
  output logic stable_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  always_comb begin
    accept   = (s2_q != stable_q) && (cnt_q == LAST);
    stable_d = accept ? s2_q : stable_q;
    // Any return to the accepted level, or an accepted change, restarts the count.
    if ((s2_q == stable_q) || accept) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_q     <= RST_VAL;
      s2_q     <= RST_VAL;
      stable_q <= RST_VAL;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;
  assign fall_o   = resetn && accept && !s2_q;

endmodule

// File: rtl/sc_io_inport.sv
// Memory-mapped input port: debounced switches on ip0, key levels plus
// sticky press flags and a wrapping press counter on ip1.
module sc_io_inport
  import sc_io_pkg::*;
#(
  parameter int SW_W      = 10,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic [SW_W-1:0]  sw,
  input  logic [KEY_W-1:0] key,
  input  logic             ip1_rd,
  output logic [31:0]      ip0,
  output logic [31:0]      ip1
);

  logic [SW_W-1:0]     sw_stable;
  logic [SW_W-1:0]     sw_fall_unused;
  logic [KEY_W-1:0]    key_stable;
  logic [KEY_W-1:0]    key_fall;
  logic [KEY_W-1:0]    pend_q, pend_d;
  logic [CNT_W_EV-1:0] press_cnt_q, press_cnt_d;

  for (genvar i = 0; i < SW_W; i++) begin : g_sw
    sc_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .RST_VAL(1'b0)) u_db (
      .clock   (clock),
      .resetn  (resetn),
      .raw_i   (sw[i]),
      .stable_o(sw_stable[i]),
      .fall_o  (sw_fall_unused[i])
    );
  end

  // Keys reset to released so a key held through reset still yields one press.
  for (genvar i = 0; i < KEY_W; i++) begin : g_key
    sc_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W), .RST_VAL(1'b1)) u_db (
      .clock   (clock),
      .resetn  (resetn),
      .raw_i   (key[i]),
      .stable_o(key_stable[i]),
      .fall_o  (key_fall[i])
    );
  end

  always_comb begin
    // A press on the read edge survives the clear.
    pend_d      = (ip1_rd ? '0 : pend_q) | key_fall;
    press_cnt_d = press_cnt_q + count_events(key_fall);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pend_q      <= '0;
      press_cnt_q <= '0;
    end else begin
      pend_q      <= pend_d;
      press_cnt_q <= press_cnt_d;
    end
  end

  always_comb begin
    ip0                          = '0;
    ip0[SW_W-1:0]                = sw_stable;
    ip1                          = '0;
    ip1[PEND_LSB +: KEY_W]       = pend_q;
    ip1[LEVEL_LSB +: KEY_W]      = ~key_stable;
    ip1[CNT_LSB +: CNT_W_EV]     = press_cnt_q;
  end

endmodule

// File: tb/tb_sc_io_inport.sv
// Bench for sc_io_inport: directed scenarios plus random stimulus, checked
// cycle by cycle against a sliding-window reference model of the port.
module tb_sc_io_inport;
  import sc_io_pkg::*;

  localparam int SW_W = 10;
  localparam int W    = 64;
  localparam int VW   = SW_W + 4;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            resetn;
  logic [SW_W-1:0] sw;
  logic [3:0]      key;
  logic            ip1_rd;
  logic [31:0]     ip0_a, ip1_a, ip0_b, ip1_b;

  int vectors     = 0;
  int miscompares = 0;

  sc_io_inport #(.SW_W(SW_W), .DB_CYCLES(4), .CNT_W(4)) dut_a (
    .clock (clock),
    .resetn(resetn),
    .sw    (sw),
    .key   (key),
    .ip1_rd(ip1_rd),
    .ip0   (ip0_a),
    .ip1   (ip1_a)
  );

  sc_io_inport #(.SW_W(SW_W), .DB_CYCLES(1), .CNT_W(2)) dut_b (
    .clock (clock),
    .resetn(resetn),
    .sw    (sw),
    .key   (key),
    .ip1_rd(ip1_rd),
    .ip0   (ip0_b),
    .ip1   (ip1_b)
  );

  // ---------------- reference model ----------------
  // Input history per clock edge; the accepted level of a bit flips once the
  // synchronised value has differed from it for DB consecutive edges.
  logic [SW_W-1:0] h_sw[$];
  logic [3:0]      h_key[$];
  bit              h_rst[$];

  logic [VW-1:0] m_stable[2];
  logic [3:0]    m_pend[2];
  logic [7:0]    m_cnt[2];

  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];

  // Synchronised {key, sw} value seen just before edge k.
  function automatic logic [VW-1:0] sync_at(int k);
    if (k < 2) return {4'hF, {SW_W{1'b0}}};
    if (h_rst[k-1] || h_rst[k-2]) return {4'hF, {SW_W{1'b0}}};
    return {h_key[k-2], h_sw[k-2]};
  endfunction

  function automatic logic [W-1:0] model_step(int inst, int db);
    int            k;
    logic [VW-1:0] cur, nxt, s;
    logic [3:0]    fall;
    bit            held;
    k = h_rst.size() - 1;
    if (h_rst[k]) begin
      m_stable[inst] = {4'hF, {SW_W{1'b0}}};
      m_pend[inst]   = 4'h0;
      m_cnt[inst]    = 8'h00;
    end else begin
      cur = m_stable[inst];
      nxt = cur;
      for (int b = 0; b < VW; b++) begin
        held = 1'b1;
        for (int j = 0; j < db; j++) begin
          if (k - j < 0 || h_rst[k-j]) begin
            held = 1'b0;
          end else begin
            s = sync_at(k - j);
            if (s[b] == cur[b]) held = 1'b0;
          end
        end
        if (held) nxt[b] = ~cur[b];
      end
      fall = cur[SW_W +: 4] & ~nxt[SW_W +: 4];
      if (ip1_rd) m_pend[inst] = 4'h0;
      m_pend[inst]   = m_pend[inst] | fall;
      m_cnt[inst]    = m_cnt[inst] + 8'($countones(fall));
      m_stable[inst] = nxt;
    end
    return {16'h0000, m_cnt[inst], ~m_stable[inst][SW_W +: 4], m_pend[inst],
            32'(m_stable[inst][SW_W-1:0])};
  endfunction

  always @(posedge clock) begin
    h_sw.push_back(sw);
    h_key.push_back(key);
    h_rst.push_back(!resetn);
    exp_q_a.push_back(model_step(0, 4));
    exp_q_b.push_back(model_step(1, 1));
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  logic [W-1:0] e_a, e_b;
  always @(negedge clock) begin
    if (exp_q_a.size() > 0) begin
      e_a = exp_q_a.pop_front();
      cmp("mon_ip0_db4", ip0_a, e_a[31:0]);
      cmp("mon_ip1_db4", ip1_a, e_a[63:32]);
    end
    if (exp_q_b.size() > 0) begin
      e_b = exp_q_b.pop_front();
      cmp("mon_ip0_db1", ip0_b, e_b[31:0]);
      cmp("mon_ip1_db1", ip1_b, e_b[63:32]);
    end
  end

  // ---------------- driver ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    resetn = 1'b0;
    sw     = 10'h3FF;
    key    = 4'hF;
    ip1_rd = 1'b1;
    tick(3);
    cmp("rst_ip0", ip0_a, 32'h0);
    cmp("rst_ip1", ip1_a, 32'h0);
    ip1_rd = 1'b0;

    // Switch latency after reset release
    resetn = 1'b1;
    tick(5);
    cmp("t1_ip0_after5", ip0_a, 32'h0);
    tick(1);
    cmp("t1_ip0_after6", ip0_a, 32'h3FF);

    // Glitch rejection and a pulse long enough to be accepted
    sw = '0;
    tick(7);
    cmp("t2_idle", ip0_a, 32'h0);
    sw = 10'h001;
    tick(3);
    sw = '0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      cmp("t2_glitch", ip0_a, 32'h0);
    end
    sw = 10'h001;
    tick(5);
    sw = '0;
    tick(1);
    cmp("t2_pulse_set", ip0_a, 32'h1);
    tick(5);
    cmp("t2_pulse_clr", ip0_a, 32'h0);

    // Key press and release
    key = 4'hB;
    tick(6);
    cmp("t3_press", ip1_a, 32'h0000_0144);
    key = 4'hF;
    tick(6);
    cmp("t3_release", ip1_a, 32'h0000_0104);

    // Read clears pend; a press on the read edge wins
    ip1_rd = 1'b1;
    tick(1);
    ip1_rd = 1'b0;
    cmp("t4_rd_clear", ip1_a, 32'h0000_0100);
    key = 4'hE;
    tick(5);
    ip1_rd = 1'b1;
    tick(1);
    ip1_rd = 1'b0;
    cmp("t4_set_wins", ip1_a, 32'h0000_0211);
    key = 4'hF;
    tick(6);

    // Counter wrap and simultaneous presses
    for (int i = 0; i < 256; i++) begin
      key = 4'hD;
      tick(6);
      key = 4'hF;
      tick(6);
    end
    cmp("t5_wrap", ip1_a, 32'h0000_0203);
    key = 4'h6;
    tick(5);
    cmp("t5_pair_before", ip1_a, 32'h0000_0203);
    tick(1);
    cmp("t5_pair", ip1_a, 32'h0000_049B);
    key = 4'hF;
    tick(6);

    // DB_CYCLES=1: key held through reset gives exactly one press
    key    = 4'hE;
    resetn = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(2);
    cmp("t6_db1_early", ip1_b, 32'h0);
    tick(1);
    cmp("t6_db1_press", ip1_b, 32'h0000_0111);
    tick(4);
    cmp("t6_db1_once", ip1_b, 32'h0000_0111);
    key = 4'hF;
    tick(6);

    // Reset in the middle of a switch debounce
    sw = 10'h008;
    tick(3);
    resetn = 1'b0;
    tick(1);
    resetn = 1'b1;
    tick(5);
    cmp("t6_mid_rst_hold", ip0_a, 32'h0);
    tick(1);
    cmp("t6_mid_rst_done", ip0_a, 32'h8);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      int idx;
      if ($urandom_range(0, 9) == 0) begin
        idx = $urandom_range(0, SW_W - 1);
        sw[idx] = ~sw[idx];
      end
      if ($urandom_range(0, 11) == 0) begin
        idx = $urandom_range(0, 3);
        key[idx] = ~key[idx];
      end
      ip1_rd = ($urandom_range(0, 7) == 0);
      resetn = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    resetn = 1'b1;
    ip1_rd = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
